// File: rtl/dq_pkg.sv
// Shared constants, helper functions and types for the dq error-term pipeline.
package dq_pkg;

   localparam int unsigned DefN   = 16;
   localparam int unsigned DefNch = 4;

   typedef logic [DefNch*DefN-1:0] term_vec_t;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned p = 1; p < v; p = p << 1) begin
         r++;
      end
      return r;
   endfunction

   function automatic longint sat_max(input int unsigned n);
      return (64'sd1 <<< (n - 1)) - 64'sd1;
   endfunction

   function automatic longint sat_min(input int unsigned n);
      return -(64'sd1 <<< (n - 1));
   endfunction

endpackage

// File: rtl/dq_sat_mult.sv
// Last two pipeline stages: full-width multiply, then shift by Q and saturate to N bits.
// Define DQ_CAL_ROUND_EN to round half up before the shift instead of truncating.
module dq_sat_mult
   import dq_pkg::*;
#(
   parameter int unsigned W = 19,
   parameter int unsigned N = 16,
   parameter int unsigned Q = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en_mul_i,
   input  logic                en_out_i,
   input  logic signed [W-1:0] diff_i,
   input  logic signed [N-1:0] dh_i,
   output logic signed [N-1:0] dq_o,
   output logic                ovf_o
);

   localparam int unsigned P = W + N;
   localparam logic signed [P:0] SatMax = (P + 1)'(sat_max(N));
   localparam logic signed [P:0] SatMin = (P + 1)'(sat_min(N));
`ifdef DQ_CAL_ROUND_EN
   localparam logic signed [P:0] Half = (P + 1)'(1) << (Q - 1);
`endif

   logic signed [P-1:0] raw_q;
   logic signed [P:0]   adj;
   logic signed [P:0]   shr;
   logic signed [N-1:0] dq_d;
   logic                ovf_d;

   always_ff @(posedge clk) begin
      if (en_mul_i) begin
         raw_q <= P'(diff_i) * P'(dh_i);
      end
   end

   // One guard bit above the product so the rounding add cannot wrap.
   always_comb begin
      adj = {raw_q[P-1], raw_q};
`ifdef DQ_CAL_ROUND_EN
      adj = adj + Half;
`endif
      shr   = adj >>> Q;
      dq_d  = shr[N-1:0];
      ovf_d = 1'b0;
      if (shr > SatMax) begin
         dq_d  = SatMax[N-1:0];
         ovf_d = 1'b1;
      end else if (shr < SatMin) begin
         dq_d  = SatMin[N-1:0];
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dq_o  <= '0;
         ovf_o <= 1'b0;
      end else if (en_out_i) begin
         dq_o  <= dq_d;
         ovf_o <= ovf_d;
      end
   end

endmodule

// File: rtl/dq_cal_pipe.sv
// dq = (sum of NCH terms - rq) * dh, pipelined with latency clog2(NCH)+3 and saturating output.
// Optional rounding before the final shift is enabled by defining DQ_CAL_ROUND_EN.
module dq_cal_pipe
   import dq_pkg::*;
#(
   parameter int unsigned N   = 16,
   parameter int unsigned Q   = 8,
   parameter int unsigned NCH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [NCH*N-1:0] d_in,
   input  logic [N-1:0]     rq,
   input  logic [N-1:0]     dh,
   input  logic             clr_sticky,
   output logic             out_valid,
   output logic [N-1:0]     dq_out,
   output logic             ovf,
   output logic             ovf_sticky
);

   localparam int unsigned S = clog2(NCH);
   localparam int unsigned W = N + S + 1;

   logic [S+3:1] vld_q;
   logic [S+3:1] en;
   logic         sticky_q;
   logic         sticky_d;

   // en[k] is the load enable of stage k's data registers.
   assign en = {vld_q[S+2:1], in_valid};

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
      end else begin
         vld_q <= en;
      end
   end

   // Heap-ordered tree: leaves at NCH..2*NCH-1, node i sums nodes 2i and 2i+1, root is node 1.
   logic signed [W-1:0] node [1:2*NCH-1];

   for (genvar j = 0; j < NCH; j++) begin : g_leaf
      assign node[NCH+j] = {{(W-N){d_in[j*N+N-1]}}, d_in[j*N +: N]};
   end

   for (genvar i = 1; i < NCH; i++) begin : g_node
      localparam int unsigned Lvl = S + 1 - clog2(i + 1);
      logic signed [W-1:0] sum_q;
      always_ff @(posedge clk) begin
         if (en[Lvl]) begin
            sum_q <= node[2*i] + node[2*i+1];
         end
      end
      assign node[i] = sum_q;
   end

   logic signed [N-1:0] rq_q [1:S];
   logic signed [N-1:0] dh_q [1:S+1];
   logic signed [W-1:0] diff_q;

   always_ff @(posedge clk) begin
      if (en[1]) begin
         rq_q[1] <= rq;
         dh_q[1] <= dh;
      end
      for (int k = 2; k <= S; k++) begin
         if (en[k]) rq_q[k] <= rq_q[k-1];
      end
      for (int k = 2; k <= S + 1; k++) begin
         if (en[k]) dh_q[k] <= dh_q[k-1];
      end
      if (en[S+1]) begin
         diff_q <= node[1] - {{(W-N){rq_q[S][N-1]}}, rq_q[S]};
      end
   end

   dq_sat_mult #(
      .W (W),
      .N (N),
      .Q (Q)
   ) u_sat_mult (
      .clk      (clk),
      .rst      (rst),
      .en_mul_i (en[S+2]),
      .en_out_i (en[S+3]),
      .diff_i   (diff_q),
      .dh_i     (dh_q[S+1]),
      .dq_o     (dq_out),
      .ovf_o    (ovf)
   );

   assign out_valid = vld_q[S+3];

   // A new overflow wins over a simultaneous clear.
   assign sticky_d = (sticky_q & ~clr_sticky) | (out_valid & ovf);

   always_ff @(posedge clk) begin
      if (rst) begin
         sticky_q <= 1'b0;
      end else begin
         sticky_q <= sticky_d;
      end
   end

   assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_dq_cal_pipe.sv
// Randomised and directed bench for dq_cal_pipe against a queue-based arithmetic model.
module tb_dq_cal_pipe;
   import dq_pkg::*;

   localparam int unsigned TN   = 16;
   localparam int unsigned TQ   = 8;
   localparam int unsigned TNCH = 4;
   localparam int          Lat  = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   term_vec_t     d_in;
   logic [TN-1:0] rq;
   logic [TN-1:0] dh;
   logic          clr_sticky;
   logic          out_valid;
   logic [TN-1:0] dq_out;
   logic          ovf;
   logic          ovf_sticky;

   always #5 clk = ~clk;

   dq_cal_pipe #(
      .N   (TN),
      .Q   (TQ),
      .NCH (TNCH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .d_in       (d_in),
      .rq         (rq),
      .dh         (dh),
      .clr_sticky (clr_sticky),
      .out_valid  (out_valid),
      .dq_out     (dq_out),
      .ovf        (ovf),
      .ovf_sticky (ovf_sticky)
   );

   int n_pass  = 0;
   int n_total = 0;
   bit chk_en  = 1'b0;
   int cyc     = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference arithmetic straight from the definition of dq.
   task automatic calc(input term_vec_t d, input logic [TN-1:0] r, input logic [TN-1:0] h,
                       output logic [TN-1:0] q, output logic o);
      longint sum, raw, sh;
      sum = 0;
      for (int k = 0; k < int'(TNCH); k++) sum += longint'($signed(d[k*TN +: TN]));
      raw = (sum - longint'($signed(r))) * longint'($signed(h));
`ifdef DQ_CAL_ROUND_EN
      raw = raw + (64'sd1 <<< (TQ - 1));
`endif
      sh = raw >>> TQ;
      o  = 1'b1;
      if (sh > 32767) q = 16'h7FFF;
      else if (sh < -32768) q = 16'h8000;
      else begin
         q = sh[TN-1:0];
         o = 1'b0;
      end
   endtask

   typedef struct {
      int            due;
      logic [TN-1:0] dq;
      logic          ovf;
   } exp_t;

   exp_t          q_exp[$];
   logic          m_valid  = 1'b0;
   logic [TN-1:0] m_dq     = '0;
   logic          m_ovf    = 1'b0;
   logic          m_sticky = 1'b0;

   initial begin
      exp_t          e;
      logic [TN-1:0] q;
      logic          o;
      forever begin
         @(posedge clk);
         cyc++;
         if (rst) begin
            q_exp.delete();
            m_valid  = 1'b0;
            m_dq     = '0;
            m_ovf    = 1'b0;
            m_sticky = 1'b0;
         end else begin
            m_sticky = (m_sticky && !clr_sticky) || (m_valid && m_ovf);
            if (q_exp.size() > 0 && q_exp[0].due == cyc) begin
               e       = q_exp.pop_front();
               m_valid = 1'b1;
               m_dq    = e.dq;
               m_ovf   = e.ovf;
            end else begin
               m_valid = 1'b0;
            end
            if (in_valid) begin
               calc(d_in, rq, dh, q, o);
               e.due = cyc + Lat - 1;
               e.dq  = q;
               e.ovf = o;
               q_exp.push_back(e);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("out_valid", 32'(out_valid), 32'(m_valid));
         if (m_valid) begin
            chk("dq_out", 32'(dq_out), 32'(m_dq));
            chk("ovf", 32'(ovf), 32'(m_ovf));
         end else begin
            chk("dq_out_hold", 32'(dq_out), 32'(m_dq));
            chk("ovf_hold", 32'(ovf), 32'(m_ovf));
         end
         chk("ovf_sticky", 32'(ovf_sticky), 32'(m_sticky));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Single pulse, then wait (bounded) for the result and pin latency and value.
   task automatic run_single(input term_vec_t d, input logic [TN-1:0] r, input logic [TN-1:0] h,
                             input logic [TN-1:0] exp_dq, input logic exp_ovf,
                             input string name);
      int lat;
      lat      = 0;
      in_valid = 1'b1;
      d_in     = d;
      rq       = r;
      dh       = h;
      step();
      in_valid = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = i;
            break;
         end
      end
      chk({name, "_latency"}, 32'(lat), 32'(Lat));
      if (lat != 0) begin
         chk({name, "_dq"}, 32'(dq_out), 32'(exp_dq));
         chk({name, "_ovf"}, 32'(ovf), 32'(exp_ovf));
      end
   endtask

   function automatic logic [TN-1:0] small_val(input int unsigned span);
      return TN'($urandom_range(0, 2 * span)) - TN'(span);
   endfunction

   task automatic rand_inputs();
      if ($urandom_range(0, 3) == 0) begin
         d_in = {$urandom, $urandom};
         rq   = TN'($urandom);
         dh   = TN'($urandom);
      end else begin
         for (int k = 0; k < int'(TNCH); k++) d_in[k*TN +: TN] = small_val(512);
         rq = small_val(512);
         dh = small_val(768);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst        = 1'b1;
      in_valid   = 1'b0;
      d_in       = '0;
      rq         = '0;
      dh         = '0;
      clr_sticky = 1'b0;
      step();
      chk_en = 1'b1;
      step();
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_dq_out", 32'(dq_out), 32'd0);
      chk("reset_ovf", 32'(ovf), 32'd0);
      chk("reset_sticky", 32'(ovf_sticky), 32'd0);
      step();

      run_single({4{16'h0100}}, 16'h0100, 16'h0200, 16'h0600, 1'b0, "basic");
      step();
      run_single({4{16'h7FFF}}, 16'h8000, 16'h7FFF, 16'h7FFF, 1'b1, "pos_sat");
      step();
      @(negedge clk);
      chk("sticky_set", 32'(ovf_sticky), 32'd1);
      step();
      clr_sticky = 1'b1;
      step();
      clr_sticky = 1'b0;
      @(negedge clk);
      chk("sticky_clear", 32'(ovf_sticky), 32'd0);
      step();
      run_single({4{16'h8000}}, 16'h7FFF, 16'h7FFF, 16'h8000, 1'b1, "neg_sat");
      clr_sticky = 1'b1;
      step();
      clr_sticky = 1'b0;
      @(negedge clk);
      chk("sticky_set_wins", 32'(ovf_sticky), 32'd1);
      step();

`ifdef DQ_CAL_ROUND_EN
      run_single(64'h1, 16'h0000, 16'h0080, 16'h0001, 1'b0, "round_plus");
      step();
      run_single(64'h0, 16'h0001, 16'h0080, 16'h0000, 1'b0, "round_minus");
`else
      run_single(64'h1, 16'h0000, 16'h0080, 16'h0000, 1'b0, "trunc_plus");
      step();
      run_single(64'h0, 16'h0001, 16'h0080, 16'hFFFF, 1'b0, "trunc_minus");
`endif
      step();

      // Streaming burst with a gap.
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         rand_inputs();
         step();
      end
      in_valid = 1'b0;
      step();
      step();
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         rand_inputs();
         step();
      end
      in_valid = 1'b0;
      repeat (10) step();

      // Random traffic with occasional sticky clears.
      for (int i = 0; i < 400; i++) begin
         in_valid   = ($urandom_range(0, 3) != 0);
         clr_sticky = ($urandom_range(0, 15) == 0);
         rand_inputs();
         step();
      end
      in_valid   = 1'b0;
      clr_sticky = 1'b0;
      repeat (10) step();

      // Reset with samples in flight.
      run_single({4{16'h0100}}, 16'h0100, 16'h0200, 16'h0600, 1'b0, "pre_reset");
      step();
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         d_in     = {4{16'h0100}};
         rq       = 16'h0100;
         dh       = 16'h0200;
         step();
      end
      rst = 1'b1;
      step();
      rst      = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("midreset_out_valid", 32'(out_valid), 32'd0);
      chk("midreset_dq_out", 32'(dq_out), 32'd0);
      repeat (10) step();
      run_single({4{16'h0080}}, 16'h0000, 16'h0100, 16'h0200, 1'b0, "post_reset");
      repeat (5) step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/dq_cal_pipe.md
Name: dq_cal_pipe

Overview:
- Parametrised successor of the dq error-term calculator.
- Computes dq = (sum of NCH I/Q correction terms − Rq) × Dh in signed Q-format fixed point.
- Fully pipelined with a valid strobe, no internal overflow, and a saturating output with per-sample and sticky overflow flags.
- Sits between the I/Q detector outputs and the loop-update stage; accepts one sample per cycle.

Parameters:
N, 16, data width of every input and output word (signed, two's complement)
Q, 8, fractional bits of all words (same format in and out)
NCH, 4, number of summed terms; power of two, 2..16
S (localparam), clog2(NCH), adder-tree depth
W (localparam), N+S+1, internal sum/difference width

Ports:
clk  in  1  clock
rst  in  1  reset
in_valid  in  1  d_in/rq/dh are valid this cycle
d_in  in  NCH*N  packed signed terms; term k at [k*N +: N]
rq  in  N  signed reference subtracted from the sum
dh  in  N  signed gain multiplier
clr_sticky  in  1  clears ovf_sticky
out_valid  out  1  dq_out valid this cycle
dq_out  out  N  saturated signed Q-format result
ovf  out  1  dq_out was saturated (qualified by out_valid)
ovf_sticky  out  1  latched OR of every ovf since reset or clear

Behaviour:
- Reset: rst, synchronous, active-high; clock clk.
- Reset clears out_valid, dq_out, ovf, ovf_sticky and the whole valid pipeline to 0; in-flight samples are discarded.
- Pipeline, stages 1..S: binary adder tree, one level per stage.
  - Operands sign-extended to W bits, so no wrap is possible.
  - rq and dh are delayed alongside in matched registers.
- Stage S+1: diff = sum − sext(rq), W bits.
- Stage S+2: raw = diff × dh, full W+N bit signed product registered.
- Stage S+3:
  - Arithmetic right shift of raw by Q (truncation toward −inf).
  - Saturate to N bits: >2^(N-1)−1 → 0x7FF..F; <−2^(N-1) → 0x800..0.
  - ovf=1 iff clamped. Register dq_out, ovf, out_valid.
- Latency: exactly S+3 cycles from in_valid to out_valid (5 for NCH=4). Throughput 1/cycle, no backpressure.
- Each stage's data registers load only when that stage's valid is 1, otherwise hold.
- When out_valid=0, dq_out and ovf hold their last values.
- ovf_sticky:
  - Set on any cycle with out_valid & ovf.
  - clr_sticky clears it.
  - Simultaneous set and clear → stays 1 (set wins).
- Bubbles in in_valid propagate unchanged; output ordering equals input ordering.
- Reset asserted mid-stream: outputs 0 on the next edge. Samples accepted with rst high are dropped.

Optional Feature:
- Macro DQ_CAL_ROUND_EN.
- Defined: before the Q shift, add 2^(Q-1) to raw (round half up); saturation is applied after rounding. Latency unchanged.
- Undefined: plain truncation as above.

Decomposition:
- Package dq_pkg:
  - clog2 constant function.
  - Saturation bound constants SAT_MAX/SAT_MIN as functions of N.
  - Typedef for the packed term vector.
- One sub-module, dq_sat_mult: stages S+2..S+3 (multiply, optional round, shift, saturate, ovf), parametrised by W, N, Q.
- Adder tree stays in the top as a generate loop.

Test Plan (N=16, Q=8, NCH=4):
1. Basic value: d_in = 4×0x0100, rq=0x0100, dh=0x0200, single pulse → exactly 5 cycles later out_valid=1, dq_out=0x0600, ovf=0.
2. Positive saturation: d_in = 4×0x7FFF, rq=0x8000, dh=0x7FFF → dq_out=0x7FFF, ovf=1, ovf_sticky=1 thereafter. Pulse clr_sticky → 0. clr_sticky in the same cycle as a new ovf → stays 1.
3. Negative saturation: d_in = 4×0x8000, rq=0x7FFF, dh=0x7FFF → dq_out=0x8000, ovf=1.
4. Rounding, diff=+1 LSB and diff=−1 LSB with dh=0x0080:
   - Without the macro: results 0x0000 and 0xFFFF.
   - With DQ_CAL_ROUND_EN: results 0x0001 and 0x0000.
5. Streaming: 8 back-to-back valid samples, then a 2-cycle gap, then 3 more → outputs in the same order with the same gaps, each matching the reference model; dq_out holds during the gaps.
6. Reset mid-stream: assert rst for 1 cycle while 3 samples are in flight → out_valid=0 and dq_out=0 next cycle; no stale samples ever emerge; the next input produces output 5 cycles later.
